// File: rtl/pipe_stage_fifo.sv
// ---------------------------------------------------------------------------
// pipe_stage_fifo
//
// Elastic pipeline stage built around a small circular buffer. It accepts
// payloads from the previous stage with a valid/ready handshake and presents
// them to the next stage in strict FIFO order. It can optionally pass data
// straight through when the buffer is empty (BYPASS=1).
//
// Parameters
//   WIDTH  : payload width in bits
//   DEPTH  : number of entries (power of two, >= 2)
//   BYPASS : 1 = zero-latency pass-through while empty, 0 = registered only
//
// Ports
//   clk_i       : clock, all state changes on the rising edge
//   rst_ni      : asynchronous active-low reset
//   flush_i     : synchronous discard of every buffered entry
//   stall_i     : freeze; no enqueue/dequeue, handshakes forced low
//   ls_valid_i  : previous stage presents in_data_i
//   in_data_i   : incoming payload
//   ts_ready_o  : this stage accepts in_data_i this cycle
//   ts_valid_o  : out_data_o is valid toward the next stage
//   out_data_o  : head entry, or in_data_i when bypassing
//   ns_ready_i  : next stage accepts out_data_o this cycle
//   count_o     : number of buffered entries (0..DEPTH)
// ---------------------------------------------------------------------------
module pipe_stage_fifo #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 2,
    parameter int BYPASS = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     stall_i,
    input  logic                     ls_valid_i,
    input  logic [WIDTH-1:0]         in_data_i,
    output logic                     ts_ready_o,
    output logic                     ts_valid_o,
    output logic [WIDTH-1:0]         out_data_o,
    input  logic                     ns_ready_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Storage is read asynchronously: the head must be visible in the same
    // cycle it becomes valid, so a registered-read RAM would add a cycle of
    // latency the handshake cannot tolerate.
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic empty;
    logic full;
    logic ts_ready;
    logic ts_valid;
    logic pass_through;
    logic push;
    logic pop;

    // -----------------------------------------------------------------------
    // Handshake and datapath selection
    // -----------------------------------------------------------------------
    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == FULL_CNT);

        // Depends only on local state and stall, never on ns_ready_i, so no
        // combinational path runs backwards through the stage. Gating with
        // rst_ni keeps both handshakes low while reset is held.
        ts_ready = rst_ni && !full && !stall_i;

        ts_valid = 1'b0;
        if (!empty) begin
            ts_valid = rst_ni && !stall_i;
        end else if (BYPASS != 0) begin
            ts_valid = rst_ni && ls_valid_i && !stall_i;
        end

        if ((BYPASS == 0) && !rst_ni) begin
            out_data_o = '0;
        end else if ((BYPASS != 0) && empty) begin
            out_data_o = in_data_i;
        end else begin
            out_data_o = mem_q[rd_ptr_q];
        end

        // Empty buffer, both neighbours ready: the payload is consumed
        // directly and never touches storage.
        pass_through = (BYPASS != 0) && empty && ls_valid_i && ns_ready_i && !stall_i;

        push = ls_valid_i && ts_ready && !flush_i && !pass_through;
        pop  = !empty && ts_valid && ns_ready_i && !flush_i;
    end

    assign ts_ready_o = ts_ready;
    assign ts_valid_o = ts_valid;
    assign count_o    = count_q;

    // -----------------------------------------------------------------------
    // Next-state for pointers and occupancy
    // -----------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush_i) begin
            // Flush wins over stall and over any concurrent handshake.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow is the wrap.
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; entries are only observable once the
    // occupancy says they were written.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_fifo
//
// Drives one BYPASS=0 and one BYPASS=1 instance (WIDTH=32, DEPTH=4) with the
// same inputs. A queue-based model per instance predicts outputs every cycle;
// directed scenarios add literal expectations, then a randomized phase runs.
// ---------------------------------------------------------------------------
module tb_pipe_stage_fifo;

    localparam int W = 32;
    localparam int D = 4;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          flush    = 1'b0;
    logic          stall    = 1'b0;
    logic          ls_valid = 1'b0;
    logic          ns_ready = 1'b0;
    logic [W-1:0]  in_data  = '0;

    logic          rdy0, vld0, rdy1, vld1;
    logic [W-1:0]  dat0, dat1;
    logic [2:0]    cnt0, cnt1;

    int n_checks = 0;
    int n_fail   = 0;
    bit model_on = 1'b1;

    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];

    always #5 clk = ~clk;

    pipe_stage_fifo #(.WIDTH(W), .DEPTH(D), .BYPASS(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .stall_i(stall),
        .ls_valid_i(ls_valid), .in_data_i(in_data), .ts_ready_o(rdy0),
        .ts_valid_o(vld0), .out_data_o(dat0), .ns_ready_i(ns_ready),
        .count_o(cnt0)
    );

    pipe_stage_fifo #(.WIDTH(W), .DEPTH(D), .BYPASS(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .stall_i(stall),
        .ls_valid_i(ls_valid), .in_data_i(in_data), .ts_ready_o(rdy1),
        .ts_valid_o(vld1), .out_data_o(dat1), .ns_ready_i(ns_ready),
        .count_o(cnt1)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Behavioural model of one instance: the queue is the buffer contents.
    task automatic model_dut(input int sel, input logic rdy, input logic vld,
                             input logic [W-1:0] dat, input logic [2:0] cnt);
        logic [W-1:0] q[$];
        bit   byp;
        int   n;
        bit   exp_rdy, exp_vld, do_pop, do_pass, do_push;
        string pfx;
        byp = (sel == 1);
        pfx = $sformatf("dut%0d", sel);
        if (sel == 0) q = q0; else q = q1;
        if (!rst_n) begin
            q.delete();
            check({pfx, ".reset_ready"}, W'(rdy), '0);
            check({pfx, ".reset_valid"}, W'(vld), '0);
            check({pfx, ".reset_count"}, W'(cnt), '0);
            if (!byp) check({pfx, ".reset_data"}, dat, '0);
        end else begin
            n       = q.size();
            exp_rdy = (n != D) && !stall;
            if (n != 0) begin
                exp_vld = !stall;
                check({pfx, ".head"}, dat, q[0]);
            end else if (byp) begin
                exp_vld = ls_valid && !stall;
                check({pfx, ".bypass_data"}, dat, in_data);
            end else begin
                exp_vld = 1'b0;
            end
            check({pfx, ".ready"}, W'(rdy), W'(exp_rdy));
            check({pfx, ".valid"}, W'(vld), W'(exp_vld));
            check({pfx, ".count"}, W'(cnt), W'(n));
            if (flush) begin
                q.delete();
            end else begin
                do_pop  = (n != 0) && exp_vld && ns_ready;
                do_pass = byp && (n == 0) && ls_valid && ns_ready && !stall;
                do_push = ls_valid && exp_rdy && !do_pass;
                if (do_pop || do_pass)
                    $display("t=%0t %s out %h", $time, pfx, do_pop ? q[0] : in_data);
                if (do_pop)  void'(q.pop_front());
                if (do_push) q.push_back(in_data);
            end
        end
        if (sel == 0) q0 = q; else q1 = q;
    endtask

    // Compare process: inputs are stable between posedge+1 and the next
    // posedge, so the falling edge sees the settled combinational outputs.
    always @(negedge clk) begin
        if (model_on) begin
            model_dut(0, rdy0, vld0, dat0, cnt0);
            model_dut(1, rdy1, vld1, dat1, cnt1);
        end
    end

    task automatic set_in(input logic lsv, input logic [W-1:0] d, input logic nsr,
                          input logic stl, input logic fl);
        ls_valid = lsv;
        in_data  = d;
        ns_ready = nsr;
        stall    = stl;
        flush    = fl;
    endtask

    task automatic tick();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held for two edges, released just after a posedge.
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("post_reset_ready0", W'(rdy0), 1);
        check("post_reset_ready1", W'(rdy1), 1);
        check("post_reset_count0", W'(cnt0), 0);

        // Fill to full with the consumer blocked, then drain in order.
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, W'(32'h11 * (i + 1)), 1'b0, 1'b0, 1'b0);
            tick();
        end
        set_in(1'b0, '0, 1'b1, 1'b0, 1'b0);
        #1;
        check("full_count0", W'(cnt0), 4);
        check("full_count1", W'(cnt1), 4);
        check("full_ready0", W'(rdy0), 0);
        for (int i = 0; i < 4; i++) begin
            check("drain_data0", dat0, W'(32'h11 * (i + 1)));
            check("drain_data1", dat1, W'(32'h11 * (i + 1)));
            tick();
            check("drain_count0", W'(cnt0), W'(3 - i));
        end

        // Steady state at count 2 with pointer wrap.
        set_in(1'b1, 32'hA0, 1'b0, 1'b0, 1'b0); tick();
        set_in(1'b1, 32'hA1, 1'b0, 1'b0, 1'b0); tick();
        for (int i = 1; i <= 8; i++) begin
            set_in(1'b1, W'(i), 1'b1, 1'b0, 1'b0);
            #1;
            if (i == 1) check("steady_first_head", dat0, 32'hA0);
            if (i == 3) check("steady_third_head", dat0, 32'h1);
            tick();
            check("steady_count0", W'(cnt0), 2);
            check("steady_count1", W'(cnt1), 2);
        end
        set_in(1'b0, '0, 1'b1, 1'b0, 1'b0);
        #1 check("steady_tail_head", dat0, 32'h7);
        tick(); tick();
        check("steady_empty0", W'(cnt0), 0);

        // Bypass through an empty buffer.
        set_in(1'b1, 32'hABCD, 1'b1, 1'b0, 1'b0);
        #1;
        check("bypass_valid1", W'(vld1), 1);
        check("bypass_data1", dat1, 32'hABCD);
        check("bypass_valid0", W'(vld0), 0);
        tick();
        check("bypass_count1", W'(cnt1), 0);
        check("bypass_count0", W'(cnt0), 1);
        set_in(1'b1, 32'hABCD, 1'b0, 1'b0, 1'b0);
        tick();
        check("bypass_blocked_count1", W'(cnt1), 1);
        check("bypass_blocked_count0", W'(cnt0), 2);
        set_in(1'b0, '0, 1'b1, 1'b0, 1'b0);
        tick(); tick();
        check("bypass_drained0", W'(cnt0), 0);
        check("bypass_drained1", W'(cnt1), 0);

        // Stall with three entries buffered.
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, W'(32'h31 + i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        set_in(1'b1, 32'h99, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_valid0", W'(vld0), 0);
            check("stall_ready0", W'(rdy0), 0);
            check("stall_valid1", W'(vld1), 0);
            check("stall_ready1", W'(rdy1), 0);
            check("stall_head0", dat0, 32'h31);
            tick();
            check("stall_count0", W'(cnt0), 3);
            check("stall_count1", W'(cnt1), 3);
        end
        set_in(1'b0, '0, 1'b1, 1'b0, 1'b0);
        #1 check("resume_head0", dat0, 32'h31);
        tick(); tick(); tick();
        check("resume_empty0", W'(cnt0), 0);

        // Flush of a full buffer while stalled and offered new data.
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, W'(32'hC0 + i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        set_in(1'b1, 32'h55, 1'b0, 1'b1, 1'b1);
        tick();
        set_in(1'b0, '0, 1'b0, 1'b0, 1'b0);
        #1;
        check("flush_count0", W'(cnt0), 0);
        check("flush_count1", W'(cnt1), 0);
        check("flush_valid0", W'(vld0), 0);
        check("flush_valid1", W'(vld1), 0);
        check("flush_ready0", W'(rdy0), 1);
        tick();
        check("flush_still_empty0", W'(cnt0), 0);

        // Asynchronous reset in the middle of a cycle.
        set_in(1'b1, 32'h61, 1'b0, 1'b0, 1'b0); tick();
        set_in(1'b1, 32'h62, 1'b0, 1'b0, 1'b0); tick();
        set_in(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("pre_reset_count0", W'(cnt0), 2);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_count0", W'(cnt0), 0);
        check("async_reset_count1", W'(cnt1), 0);
        check("async_reset_valid0", W'(vld0), 0);
        check("async_reset_ready0", W'(rdy0), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        set_in(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
        tick();
        check("after_reset_data0", dat0, 32'h77);
        check("after_reset_data1", dat1, 32'h77);
        check("after_reset_count0", W'(cnt0), 1);
        check("after_reset_valid0", W'(vld0), 1);
        set_in(1'b0, '0, 1'b1, 1'b0, 1'b0);
        tick();

        // Randomized traffic; consumer readiness varies per block so that
        // both full and empty regimes are visited.
        for (int blk = 0; blk < 6; blk++) begin
            int p_ns;
            p_ns = (blk % 3 == 0) ? 25 : ((blk % 3 == 1) ? 60 : 90);
            for (int c = 0; c < 80; c++) begin
                set_in($urandom_range(0, 99) < 70,
                       W'($urandom),
                       $urandom_range(0, 99) < p_ns,
                       $urandom_range(0, 99) < 10,
                       $urandom_range(0, 99) < 3);
                tick();
            end
        end

        set_in(1'b0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        model_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_fifo.md
PIPE_STAGE_FIFO -- requirements
Module: pipe_stage_fifo

Interface
REQ-001 Parameter WIDTH, default 32: payload width in bits.
REQ-002 Parameter DEPTH, default 2: entry count; power of two, >= 2.
REQ-003 Parameter BYPASS, default 0: 1 = empty-buffer combinational pass-through; 0 = registered only.
REQ-004 clock  input  1  sole clock; all state updates on posedge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous discard of all buffered entries.
REQ-007 stall  input  1  freeze: no enqueue, no dequeue while high.
REQ-008 ls_valid  input  1  upstream (last stage) has valid in_data.
REQ-009 in_data  input  WIDTH  upstream payload.
REQ-010 ts_ready  output  1  this stage accepts in_data this cycle.
REQ-011 ts_valid  output  1  out_data valid toward next stage.
REQ-012 out_data  output  WIDTH  head payload (or bypassed in_data).
REQ-013 ns_ready  input  1  next stage accepts out_data this cycle.
REQ-014 count  output  $clog2(DEPTH)+1  number of buffered entries, 0..DEPTH.

Function
REQ-015 Storage: circular buffer of DEPTH entries; read/write pointers $clog2(DEPTH) bits, wrap from DEPTH-1 to 0.
REQ-016 ts_ready = (count != DEPTH) && !stall; no combinational path from ns_ready to ts_ready.
REQ-017 Enqueue (push) when ls_valid && ts_ready && !flush, excluding the bypass case of REQ-021.
REQ-018 Dequeue (pop) when count != 0 && ts_valid && ns_ready && !flush.
REQ-019 BYPASS=0: ts_valid = (count != 0) && !stall; out_data = entry at read pointer; min latency in->out 1 cycle.
REQ-020 BYPASS=1, count==0: ts_valid = ls_valid && !stall; out_data = in_data (0-cycle latency).
REQ-021 BYPASS=1, count==0, ls_valid && ns_ready && !stall: data passes through, no entry written, count unchanged.
REQ-022 Simultaneous push and pop: both pointers advance, count unchanged; legal at any count < DEPTH.
REQ-023 Full (count==DEPTH): push impossible (ts_ready=0); pop allowed; count becomes DEPTH-1 next cycle.
REQ-024 Empty, BYPASS=0: ts_valid=0; out_data content don't-care.
REQ-025 stall high: pointers, count and storage hold; ts_valid=0, ts_ready=0 (bubble toward next stage).
REQ-026 flush high: next cycle count=0 and pointers=0; concurrent push/pop ignored; flush overrides stall.
REQ-027 flush high same cycle: ts_valid still reflects the pre-flush state; consumers ignore it as in the pipeline controller's flush convention.
REQ-028 count arithmetic: count_next = count + push - pop, never exceeds DEPTH nor drops below 0.
REQ-029 Payload passes unmodified; FIFO order strictly preserved.

Reset
REQ-030 reset low asynchronously clears pointers and count to 0; storage contents need not be cleared.
REQ-031 During reset: ts_valid=0, ts_ready=0, count=0; out_data = 0 when BYPASS=0.
REQ-032 Reset asserted mid-operation discards all entries; first cycle after release ts_ready=1 (if stall=0), count=0.
REQ-033 Reset release is synchronised to clock by the parent; block is clean from the first posedge after deassertion.

Verification (WIDTH=32, DEPTH=4 unless stated)
REQ-034 BYPASS=0, ns_ready=0, push 0x11,0x22,0x33,0x44 -> count=4, ts_ready=0; then ns_ready=1 -> out 0x11,0x22,0x33,0x44 on consecutive cycles, count 3,2,1,0.
REQ-035 BYPASS=0, count=2, continuous ls_valid and ns_ready for 8 cycles with values 0x1..0x8 -> count stays 2, outputs in order, pointer wrap exercised.
REQ-036 BYPASS=1, empty, ls_valid=1 in_data=0xABCD, ns_ready=1 -> ts_valid=1, out_data=0xABCD same cycle, count stays 0; with ns_ready=0 -> count=1 next cycle.
REQ-037 count=3, stall=1 with ls_valid=1, ns_ready=1 for 3 cycles -> ts_valid=0, ts_ready=0, count=3, head unchanged; stall=0 resumes order.
REQ-038 count=4 (full), flush=1 with stall=1 and ls_valid=1 -> next cycle count=0, ts_valid=0, ts_ready=1, input 0x55 not stored.
REQ-039 count=2, reset pulsed low mid-cycle -> count=0, ts_valid=0 immediately (asynchronous); after release push 0x77 -> out_data=0x77 next cycle.
